im_loader: RTL and testbench

Byte-stream writer for the instruction memory: it accepts a framed stream of program bytes and emits word writes (address, data, write strobe) into the instruction-memory array before the CPU is released from reset. It assembles 4 bytes per word, MSB first, so byte order matches the hex word order of the program image. It tracks the word count and flags malformed frames. It sits between the host/debug byte link and the write port of the instruction store.

---
 rtl/im_loader_pkg.sv | 16 +
 rtl/im_word_packer.sv | 35 +++
 rtl/im_loader.sv | 138 +++++++++++++
 tb/tb_im_loader.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/im_loader_pkg.sv
// Shared types and constants for the instruction-memory loader.
package im_loader_pkg;

    typedef logic [2:0] state_t;

    localparam state_t IDLE   = 3'd0;
    localparam state_t HDR_HI = 3'd1;
    localparam state_t HDR_LO = 3'd2;
    localparam state_t DATA   = 3'd3;
    localparam state_t CSUM   = 3'd4;
    localparam state_t DONE   = 3'd5;

    localparam int HDR_W          = 16;
    localparam int BYTES_PER_WORD = 4;

endpackage

// File: rtl/im_word_packer.sv
// Packs bytes MSB-first into 32-bit words; wordDone is combinational with the 4th byte strobe.
// No backpressure of its own: it consumes a byte whenever byteStrobe is high.
module im_word_packer
    import im_loader_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        clear,
    input  logic [7:0]  byteIn,
    input  logic        byteStrobe,
    output logic [31:0] word,
    output logic        wordDone
);

    logic [23:0] shiftReg;
    logic [1:0]  byteCnt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            shiftReg <= '0;
            byteCnt  <= '0;
        end else if (clear) begin
            shiftReg <= '0;
            byteCnt  <= '0;
        end else if (byteStrobe) begin
            shiftReg <= {shiftReg[15:0], byteIn};
            byteCnt  <= byteCnt + 2'd1;
        end
    end

    // The completing byte is folded in directly so the word is ready on the same edge.
    assign word     = {shiftReg, byteIn};
    assign wordDone = byteStrobe && (byteCnt == 2'(BYTES_PER_WORD - 1));

endmodule

// File: rtl/im_loader.sv
// Framed byte stream to instruction-memory word writes; we/addr/wdata one cycle after a word's 4th byte.
// in_ready high only while a frame is open; IM_LOADER_CHECKSUM_EN adds a trailing XOR checksum byte.
module im_loader
    import im_loader_pkg::*;
#(
    parameter int ADDR_W = 10,
    parameter int DEPTH  = 1024
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              in_valid,
    input  logic [7:0]        in_data,
    output logic              in_ready,
    output logic              we,
    output logic [ADDR_W-1:0] addr,
    output logic [31:0]       wdata,
    output logic              busy,
    output logic              done,
    output logic              err
);

    localparam logic [HDR_W:0] DEPTH_LIM = (HDR_W + 1)'(DEPTH);

    state_t           state;
    logic [7:0]       hdrHi;
    logic [HDR_W-1:0] wordCount;
    logic [HDR_W-1:0] wordIdx;
    logic [HDR_W-1:0] hdrWord;
    logic             hdrOk;
    logic             xfer;
    logic             frameStart;
    logic             packStrobe;
    logic             wordDone;
    logic             lastWord;
    logic [31:0]      packedWord;

    assign in_ready   = (state == HDR_HI) || (state == HDR_LO) || (state == DATA) || (state == CSUM);
    assign busy       = in_ready;
    assign done       = (state == DONE);
    assign xfer       = in_valid && in_ready;
    assign frameStart = start && ((state == IDLE) || (state == DONE));
    assign packStrobe = xfer && (state == DATA);
    assign hdrWord    = {hdrHi, in_data};
    assign hdrOk      = (hdrWord != '0) && ({1'b0, hdrWord} <= DEPTH_LIM);
    // Full 16-bit compare so a count equal to DEPTH does not alias onto address 0.
    assign lastWord   = (wordIdx == wordCount - 16'd1);

    im_word_packer u_packer (
        .clk        (clk),
        .reset      (reset),
        .clear      (frameStart),
        .byteIn     (in_data),
        .byteStrobe (packStrobe),
        .word       (packedWord),
        .wordDone   (wordDone)
    );

`ifdef IM_LOADER_CHECKSUM_EN
    logic [7:0] csumAcc;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            csumAcc <= '0;
        end else if (frameStart) begin
            csumAcc <= '0;
        end else if (packStrobe) begin
            csumAcc <= csumAcc ^ in_data;
        end
    end
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            hdrHi     <= '0;
            wordCount <= '0;
            wordIdx   <= '0;
            we        <= 1'b0;
            addr      <= '0;
            wdata     <= '0;
            err       <= 1'b0;
        end else begin
            we <= 1'b0;
            if (wordDone) begin
                we      <= 1'b1;
                addr    <= wordIdx[ADDR_W-1:0];
                wdata   <= packedWord;
                wordIdx <= wordIdx + 16'd1;
            end
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        state <= HDR_HI;
                        err   <= 1'b0;
                    end
                end
                HDR_HI: begin
                    if (xfer) begin
                        hdrHi <= in_data;
                        state <= HDR_LO;
                    end
                end
                HDR_LO: begin
                    if (xfer) begin
                        if (hdrOk) begin
                            wordCount <= hdrWord;
                            wordIdx   <= '0;
                            state     <= DATA;
                        end else begin
                            err   <= 1'b1;
                            state <= DONE;
                        end
                    end
                end
                DATA: begin
                    if (wordDone && lastWord) begin
`ifdef IM_LOADER_CHECKSUM_EN
                        state <= CSUM;
`else
                        state <= DONE;
`endif
                    end
                end
`ifdef IM_LOADER_CHECKSUM_EN
                CSUM: begin
                    if (xfer) begin
                        err   <= (in_data != csumAcc);
                        state <= DONE;
                    end
                end
`endif
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_im_loader.sv
// Randomized frame stimulus for im_loader checked against a frame-level reference model.
module tb_im_loader;

    typedef logic [7:0] u8;
    typedef u8 uq_t[$];

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic        in_valid = 1'b0;
    logic [7:0]  in_data = 8'h00;
    logic        in_ready;
    logic        we;
    logic [9:0]  addr;
    logic [31:0] wdata;
    logic        busy;
    logic        done;
    logic        err;

    int nCompared = 0;
    int nMismatch = 0;
    int cycle = 0;

    logic [9:0]  gotA[$];
    logic [31:0] gotD[$];
    int          gotCyc[$];
    logic        gotDone[$];
    logic [9:0]  expA[$];
    logic [31:0] expD[$];

    always #5 clk = ~clk;

    im_loader #(.ADDR_W(10), .DEPTH(1024)) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .in_valid (in_valid),
        .in_data  (in_data),
        .in_ready (in_ready),
        .we       (we),
        .addr     (addr),
        .wdata    (wdata),
        .busy     (busy),
        .done     (done),
        .err      (err)
    );

    always @(posedge clk) begin
        #1;
        cycle++;
        if (we === 1'b1) begin
            gotA.push_back(addr);
            gotD.push_back(wdata);
            gotCyc.push_back(cycle);
            gotDone.push_back(done);
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nCompared++;
        if (got !== exp) begin
            nMismatch++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic uq_t addCsum(input uq_t q);
        uq_t r = q;
`ifdef IM_LOADER_CHECKSUM_EN
        u8 x = 8'h00;
        for (int i = 2; i < q.size(); i++) x ^= q[i];
        r.push_back(x);
`endif
        return r;
    endfunction

    function automatic uq_t frameOf(input int n);
        uq_t q;
        q.push_back(u8'(n >> 8));
        q.push_back(u8'(n));
        for (int i = 0; i < 4 * n; i++) q.push_back(u8'($urandom));
        return addCsum(q);
    endfunction

    // Reference: decode the frame as a whole into the list of writes it should produce.
    task automatic model(input uq_t q, output logic expErr);
        int n;
        expA.delete();
        expD.delete();
        n = int'({q[0], q[1]});
        if (n == 0 || n > 1024) begin
            expErr = 1'b1;
            return;
        end
        for (int i = 0; i < n; i++) begin
            expA.push_back(10'(i));
            expD.push_back({q[2+4*i], q[3+4*i], q[4+4*i], q[5+4*i]});
        end
        expErr = 1'b0;
`ifdef IM_LOADER_CHECKSUM_EN
        begin
            u8 x = 8'h00;
            for (int i = 0; i < 4 * n; i++) x ^= q[2+i];
            expErr = (q.size() <= 2 + 4 * n) || (q[2+4*n] != x);
        end
`endif
    endtask

    task automatic checkWrites(input string tag);
        chk({tag, " writeCount"}, gotA.size(), expA.size());
        for (int i = 0; i < gotA.size() && i < expA.size(); i++) begin
            chk({tag, " addr"}, gotA[i], expA[i]);
            chk({tag, " wdata"}, gotD[i], expD[i]);
        end
    endtask

    task automatic beginFrame(input string tag);
        @(negedge clk);
        start = 1'b1;
        gotA.delete();
        gotD.delete();
        gotCyc.delete();
        gotDone.delete();
        @(negedge clk);
        start = 1'b0;
        chk({tag, " busyAfterStart"}, busy, 1);
        chk({tag, " doneAfterStart"}, done, 0);
    endtask

    // mode 0: full rate, 1: valid every other cycle, 2: random valid.
    task automatic sendBytes(input uq_t q, input int mode, input int startAt);
        int idx = 0;
        int budget = 0;
        bit tog = 1'b0;
        while (idx < q.size() && budget < 20000) begin
            @(negedge clk);
            budget++;
            tog = !tog;
            case (mode)
                0:       in_valid = 1'b1;
                1:       in_valid = tog;
                default: in_valid = 1'($urandom_range(0, 1));
            endcase
            in_data = q[idx];
            start   = (idx == startAt);
            if (in_valid && in_ready) idx++;
        end
        if (idx < q.size()) chk("sendTimeout", idx, q.size());
        @(negedge clk);
        in_valid = 1'b0;
        start    = 1'b0;
        in_data  = 8'h00;
    endtask

    task automatic runFrame(input string tag, input uq_t q, input int mode, input int startAt);
        logic expErr;
        model(q, expErr);
        beginFrame(tag);
        sendBytes(q, mode, startAt);
        chk({tag, " done"}, done, 1);
        chk({tag, " err"}, err, expErr);
        chk({tag, " busyEnd"}, busy, 0);
        chk({tag, " readyEnd"}, in_ready, 0);
        repeat (2) @(negedge clk);
        chk({tag, " doneHeld"}, done, 1);
        checkWrites(tag);
    endtask

    initial begin
        uq_t q;
        logic e;

        #2;
        chk("rst in_ready", in_ready, 0);
        chk("rst we", we, 0);
        chk("rst addr", addr, 0);
        chk("rst wdata", wdata, 0);
        chk("rst busy", busy, 0);
        chk("rst done", done, 0);
        chk("rst err", err, 0);
        @(negedge clk);
        reset = 1'b0;
        repeat (2) @(negedge clk);
        chk("idle ready", in_ready, 0);

        q = '{8'h00, 8'h02, 8'h12, 8'h34, 8'h56, 8'h78, 8'h9A, 8'hBC, 8'hDE, 8'hF0};
        runFrame("n2", addCsum(q), 0, -1);
        if (gotCyc.size() == 2) begin
            chk("n2 weSpacing", gotCyc[1] - gotCyc[0], 4);
            chk("n2 doneWithLastWe", gotDone[1], 1);
            chk("n2 firstWeNotDone", gotDone[0], 0);
        end

        q = '{8'h00, 8'h00};
        runFrame("hdr0", q, 0, -1);
        q = '{8'h04, 8'h01};
        runFrame("hdr1025", q, 0, -1);
        q = '{8'hFF, 8'hFF};
        runFrame("hdrFFFF", q, 2, -1);

        runFrame("n1024", frameOf(1024), 1, -1);

        q = frameOf(8);
        model(q, e);
        beginFrame("midRst");
        sendBytes(q[0:23], 0, -1);
        reset = 1'b1;
        #1;
        chk("midRst in_ready", in_ready, 0);
        chk("midRst we", we, 0);
        chk("midRst addr", addr, 0);
        chk("midRst wdata", wdata, 0);
        chk("midRst busy", busy, 0);
        chk("midRst done", done, 0);
        chk("midRst err", err, 0);
        repeat (3) @(negedge clk);
        expA = expA[0:4];
        expD = expD[0:4];
        checkWrites("midRst");
        reset = 1'b0;
        runFrame("afterRst", frameOf(3), 0, -1);

        runFrame("startInData", frameOf(4), 0, 10);
        runFrame("startInDataStall", frameOf(3), 2, 7);

`ifdef IM_LOADER_CHECKSUM_EN
        q = '{8'h00, 8'h01, 8'h01, 8'h02, 8'h03, 8'h04, 8'h04};
        runFrame("csumGood", q, 0, -1);
        q = '{8'h00, 8'h01, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05};
        runFrame("csumBad", q, 0, -1);
`endif

        for (int k = 0; k < 8; k++) begin
            runFrame("rand", frameOf(int'($urandom_range(1, 12))), 2, -1);
        end
        runFrame("randFull", frameOf(int'($urandom_range(1, 12))), 0, -1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatch);
        $finish;
    end

endmodule
